// File: rtl/multi_wave_pwm_pkg.sv
// Shared mode encodings and dither LFSR constants for multi_wave_pwm.
// Latency: n/a (constants only).
// Backpressure: n/a.
package multi_wave_pwm_pkg;

  localparam logic [2:0] MODE_SIN = 3'd0;
  localparam logic [2:0] MODE_COS = 3'd1;
  localparam logic [2:0] MODE_SAW = 3'd2;
  localparam logic [2:0] MODE_TRI = 3'd3;
  localparam logic [2:0] MODE_SQR = 3'd4;
  localparam logic [2:0] MODE_MID = 3'd5;
  localparam logic [2:0] MODE_OFF = 3'd6;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: waveform select, amplitude shift, offset-binary duty, compare, activity LED.
// Latency: duty loads on the period-boundary edge; pwm_out trails the counter by one cycle.
// Backpressure: none; inputs are sampled only at the load edge.
module pwm_channel
  import multi_wave_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int LED_DIV  = 10
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                load,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] sin_top,
  input  logic [PWM_BITS-1:0] cos_top,
  input  logic [PWM_BITS:0]   phase_top,
  input  logic [2:0]          mode,
  input  logic [1:0]          amp_shift,
  input  logic                dither,
  output logic                pwm_out,
  output logic                pwm_led
);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [LED_DIV-1:0]  led_cnt_q, led_cnt_d;
  logic                pwm_out_q, pwm_out_d;
  logic                pwm_led_q, pwm_led_d;

  logic signed [PWM_BITS-1:0] sel;
  logic signed [PWM_BITS-1:0] shifted;
  logic [PWM_BITS-1:0]        tri_lo;
  logic [PWM_BITS-1:0]        duty_next;
  logic [PWM_BITS:0]          sum;
  logic [PWM_BITS-1:0]        duty_new;

  always_comb begin
    sel     = (mode == MODE_COS) ? cos_top : sin_top;
    shifted = sel >>> amp_shift;
    tri_lo  = phase_top[PWM_BITS-1:0];

    case (mode)
      MODE_SIN, MODE_COS: duty_next = {~shifted[PWM_BITS-1], shifted[PWM_BITS-2:0]};
      MODE_SAW:           duty_next = phase_top[PWM_BITS:1];
      MODE_TRI:           duty_next = phase_top[PWM_BITS] ? ~tri_lo : tri_lo;
      MODE_SQR:           duty_next = {PWM_BITS{phase_top[PWM_BITS]}};
      MODE_MID:           duty_next = {1'b1, {(PWM_BITS-1){1'b0}}};
      default:            duty_next = '0;
    endcase

    // Dither saturates at full scale and never lifts a zero duty.
    sum = {1'b0, duty_next} + (PWM_BITS+1)'(dither);
    if (duty_next == '0) begin
      duty_new = '0;
    end else if (sum[PWM_BITS]) begin
      duty_new = '1;
    end else begin
      duty_new = sum[PWM_BITS-1:0];
    end

    duty_d    = load ? duty_new : duty_q;
    pwm_out_d = (cnt < duty_q);

    led_cnt_d = led_cnt_q;
    pwm_led_d = pwm_led_q;
    if (load && (duty_new != '0)) begin
      led_cnt_d = led_cnt_q + LED_DIV'(1);
      if (led_cnt_q == {LED_DIV{1'b1}}) begin
        pwm_led_d = ~pwm_led_q;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      duty_q    <= '0;
      led_cnt_q <= '0;
      pwm_out_q <= 1'b0;
      pwm_led_q <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      led_cnt_q <= led_cnt_d;
      pwm_out_q <= pwm_out_d;
      pwm_led_q <= pwm_led_d;
    end
  end

  assign pwm_out = pwm_out_q;
  assign pwm_led = pwm_led_q;

endmodule

// File: rtl/multi_wave_pwm.sv
// Multi-channel PWM front end for CORDIC sin/cos plus phase-accumulator shapes; optional dither via MULTI_WAVE_PWM_DITHER_EN.
// Latency: duty loads when the counter wraps; pwm_out is registered one cycle behind the counter.
// Backpressure: none; sample_valid is a strobe and is always accepted.
module multi_wave_pwm
  import multi_wave_pwm_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int PWM_BITS   = 8,
  parameter int CH         = 2,
  parameter int FREQ_WIDTH = 16,
  parameter int LED_DIV    = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [FREQ_WIDTH-1:0] freq,
  input  logic [WIDTH-1:0]      sin_in,
  input  logic [WIDTH-1:0]      cos_in,
  input  logic                  sample_valid,
  input  logic [3*CH-1:0]       mode,
  input  logic [2*CH-1:0]       amp_shift,
  output logic [CH-1:0]         pwm_out,
  output logic [CH-1:0]         pwm_led,
  output logic                  period_tick
);

  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [FREQ_WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0]      sin_h_q, sin_h_d;
  logic [WIDTH-1:0]      cos_h_q, cos_h_d;
  logic                  period_tick_q, period_tick_d;
  logic                  load;
  logic [CH-1:0]         dither;

  // Channels load from phase/samples as they stand before this edge's updates.
  always_comb begin
    load          = (cnt_q == {PWM_BITS{1'b1}});
    cnt_d         = cnt_q + PWM_BITS'(1);
    phase_d       = load ? (phase_q + freq) : phase_q;
    sin_h_d       = sample_valid ? sin_in : sin_h_q;
    cos_h_d       = sample_valid ? cos_in : cos_h_q;
    period_tick_d = load;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= '0;
      phase_q       <= '0;
      sin_h_q       <= '0;
      cos_h_q       <= '0;
      period_tick_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      sin_h_q       <= sin_h_d;
      cos_h_q       <= cos_h_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign period_tick = period_tick_q;

`ifdef MULTI_WAVE_PWM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (period_tick_q) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_dither
    assign dither[c] = lfsr_q[c % 16];
  end
`else
  assign dither = '0;
`endif

  // Only the top PWM_BITS of each held sample reach the duty path.
  if (WIDTH > PWM_BITS) begin : g_lsb_sink
    logic unused_sample_lsbs;
    assign unused_sample_lsbs = ^{sin_h_q[WIDTH-PWM_BITS-1:0], cos_h_q[WIDTH-PWM_BITS-1:0]};
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .LED_DIV  (LED_DIV)
    ) u_ch (
      .clock     (clock),
      .resetn    (resetn),
      .load      (load),
      .cnt       (cnt_q),
      .sin_top   (sin_h_q[WIDTH-1 -: PWM_BITS]),
      .cos_top   (cos_h_q[WIDTH-1 -: PWM_BITS]),
      .phase_top (phase_q[FREQ_WIDTH-1 -: PWM_BITS+1]),
      .mode      (mode[3*c +: 3]),
      .amp_shift (amp_shift[2*c +: 2]),
      .dither    (dither[c]),
      .pwm_out   (pwm_out[c]),
      .pwm_led   (pwm_led[c])
    );
  end

endmodule

// File: tb/tb_multi_wave_pwm.sv
// Self-checking bench for multi_wave_pwm: vector table, hand-written period sequences, randomized run vs a period-level model.
module tb_multi_wave_pwm;

  localparam int WIDTH   = 12;
  localparam int PB      = 8;
  localparam int CH      = 2;
  localparam int FW      = 16;
  localparam int LED_DIV = 2;
  localparam int PER     = 1 << PB;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [FW-1:0]     freq = '0;
  logic [WIDTH-1:0]  sin_in = '0;
  logic [WIDTH-1:0]  cos_in = '0;
  logic              sample_valid = 1'b0;
  logic [3*CH-1:0]   mode = '0;
  logic [2*CH-1:0]   amp_shift = '0;
  logic [CH-1:0]     pwm_out;
  logic [CH-1:0]     pwm_led;
  logic              period_tick;

  always #5 clock = ~clock;

  multi_wave_pwm #(
    .WIDTH(WIDTH), .PWM_BITS(PB), .CH(CH), .FREQ_WIDTH(FW), .LED_DIV(LED_DIV)
  ) dut (
    .clock(clock), .resetn(resetn), .freq(freq), .sin_in(sin_in), .cos_in(cos_in),
    .sample_valid(sample_valid), .mode(mode), .amp_shift(amp_shift),
    .pwm_out(pwm_out), .pwm_led(pwm_led), .period_tick(period_tick)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: edges since reset release, phase, held samples, per-period duty, LEDs.
  int               n;
  int               m_phase;
  logic [WIDTH-1:0] m_sin, m_cos;
  int               m_duty [CH];
  int               m_led  [CH];
  int               m_lcnt [CH];

  typedef struct {
    logic [2:0]       md;
    logic [1:0]       amp;
    logic [WIDTH-1:0] sv;
    logic [WIDTH-1:0] cv;
    int               exp;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic int ref_duty(input int md, input int amp, input logic [WIDTH-1:0] sv,
                                  input logic [WIDTH-1:0] cv, input int ph);
    int s;
    int t;
    t = (ph / 128) % 256;
    case (md)
      0, 1: begin
        s = (md == 0) ? int'($signed(sv)) : int'($signed(cv));
        s = s >>> (WIDTH - PB);
        s = s >>> amp;
        return s + 128;
      end
      2: return ph / 256;
      3: return (ph >= 32768) ? 255 - t : t;
      4: return (ph >= 32768) ? 255 : 0;
      5: return 128;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    m_phase = 0;
    m_sin = '0;
    m_cos = '0;
    for (int c = 0; c < CH; c++) begin
      m_duty[c] = 0;
      m_led[c]  = 0;
      m_lcnt[c] = 0;
    end
  endtask

  // One clock: advance the model for this edge, then compare at the falling edge.
  task automatic step();
    logic [CH-1:0] exp_pwm;
    logic [CH-1:0] exp_led;
    int            exp_tick;
    int            d;
    @(posedge clock);
    n++;
    for (int c = 0; c < CH; c++) exp_pwm[c] = (((n - 1) % PER) < m_duty[c]);
    exp_tick = ((n % PER) == 0) ? 1 : 0;
    if ((n % PER) == 0) begin
      for (int c = 0; c < CH; c++) begin
        d = ref_duty(int'(mode[3*c +: 3]), int'(amp_shift[2*c +: 2]), m_sin, m_cos, m_phase);
        m_duty[c] = d;
        if (d != 0) begin
          m_lcnt[c]++;
          if (m_lcnt[c] == (1 << LED_DIV)) begin
            m_lcnt[c] = 0;
            m_led[c]  = 1 - m_led[c];
          end
        end
      end
      m_phase = (m_phase + int'(freq)) % 65536;
    end
    if (sample_valid) begin
      m_sin = sin_in;
      m_cos = cos_in;
    end
    for (int c = 0; c < CH; c++) exp_led[c] = m_led[c][0];
    @(negedge clock);
    check("pwm_out", int'(pwm_out), int'(exp_pwm));
    check("pwm_led", int'(pwm_led), int'(exp_led));
    check("period_tick", int'(period_tick), exp_tick);
    sample_valid = 1'b0;
  endtask

  task automatic run_period(output int hi0);
    hi0 = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (pwm_out[0]) hi0++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_pwm_led", int'(pwm_led), 0);
    check("rst_period_tick", int'(period_tick), 0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  int h;

  initial begin
    tbl[0]  = '{3'd0, 2'd0, 12'h7FF, 12'h000, 255};
    tbl[1]  = '{3'd0, 2'd0, 12'h000, 12'h000, 128};
    tbl[2]  = '{3'd0, 2'd0, 12'h800, 12'h000, 0};
    tbl[3]  = '{3'd0, 2'd1, 12'h7FF, 12'h000, 191};
    tbl[4]  = '{3'd1, 2'd0, 12'h000, 12'h400, 192};
    tbl[5]  = '{3'd1, 2'd2, 12'h000, 12'hC00, 112};
    tbl[6]  = '{3'd0, 2'd3, 12'h800, 12'h000, 112};
    tbl[7]  = '{3'd5, 2'd3, 12'h800, 12'h800, 128};
    tbl[8]  = '{3'd6, 2'd0, 12'h7FF, 12'h7FF, 0};
    tbl[9]  = '{3'd7, 2'd0, 12'h7FF, 12'h7FF, 0};
    tbl[10] = '{3'd0, 2'd2, 12'h7F0, 12'h000, 159};

    model_reset();

    for (int i = 0; i < 11; i++) begin
      mode      = {3'd5, tbl[i].md};
      amp_shift = {2'd0, tbl[i].amp};
      freq      = '0;
      sin_in    = tbl[i].sv;
      cos_in    = tbl[i].cv;
      do_reset();
      sample_valid = 1'b1;
      run_period(h);
      check("tbl_first_period", h, 0);
      run_period(h);
      check($sformatf("tbl%0d_duty", i), h, tbl[i].exp);
    end

    // Square wave alternates full/empty once phase starts moving.
    mode = {3'd6, 3'd4}; freq = 16'h8000;
    do_reset();
    foreach (tbl[k]) if (k < 5) begin
      int sq_exp [5] = '{0, 0, 255, 0, 255};
      run_period(h);
      check($sformatf("square_p%0d", k), h, sq_exp[k]);
    end

    // Sawtooth ramps up; with a negative step it wraps 0 -> 255 -> 254.
    mode = {3'd3, 3'd2}; freq = 16'h0100;
    do_reset();
    foreach (tbl[k]) if (k < 5) begin
      int saw_exp [5] = '{0, 0, 1, 2, 3};
      run_period(h);
      check($sformatf("saw_up_p%0d", k), h, saw_exp[k]);
    end
    freq = 16'hFF00;
    do_reset();
    foreach (tbl[k]) if (k < 4) begin
      int saw_dn [4] = '{0, 0, 255, 254};
      run_period(h);
      check($sformatf("saw_wrap_p%0d", k), h, saw_dn[k]);
    end

    mode = {3'd2, 3'd3}; freq = 16'h4000;
    do_reset();
    foreach (tbl[k]) if (k < 5) begin
      int tri_exp [5] = '{0, 0, 128, 255, 127};
      run_period(h);
      check($sformatf("tri_p%0d", k), h, tri_exp[k]);
    end

    // LED cadence, then a mid-period reset while the output is high.
    mode = {3'd5, 3'd0}; amp_shift = '0; freq = '0; sin_in = 12'h7FF;
    do_reset();
    sample_valid = 1'b1;
    for (int p = 0; p < 4; p++) begin
      run_period(h);
      check($sformatf("led_seq_p%0d", p), h, (p == 0) ? 0 : 255);
      if (p == 2) check("led_before_4th_load", int'(pwm_led[0]), 0);
      if (p == 3) check("led_after_4th_load", int'(pwm_led[0]), 1);
    end
    for (int i = 0; i < 50; i++) step();
    check("pre_reset_pwm_high", int'(pwm_out[0]), 1);
    do_reset();
    run_period(h);
    check("post_reset_first_period", h, 0);

    // Mode change mid-period only affects the following period.
    mode = {3'd5, 3'd0}; sin_in = 12'h7FF;
    do_reset();
    sample_valid = 1'b1;
    run_period(h);
    run_period(h);
    h = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == 100) mode = {3'd5, 3'd6};
      step();
      if (pwm_out[0]) h++;
    end
    check("mode_change_current", h, 255);
    run_period(h);
    check("mode_change_next", h, 0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 40 * PER; i++) begin
      if ($urandom_range(0, 31) == 0) mode = (3*CH)'($urandom);
      if ($urandom_range(0, 31) == 0) amp_shift = (2*CH)'($urandom);
      if ($urandom_range(0, 63) == 0) freq = FW'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        sin_in = WIDTH'($urandom);
        cos_in = WIDTH'($urandom);
        sample_valid = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
